// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit arbiter slice.
//   - UART_DATA_BITS : width of one UART byte lane
//   - arb_state_t    : arbiter FSM states (IDLE / TAG / PASS)
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    PASS = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin priority picker. Returns the first set bit of
//   req, searching ptr, ptr+1, ... and wrapping at NUM_REQ.
//   Ports:
//     req  in  NUM_REQ   request vector
//     ptr  in  ID_BITS   highest-priority index, must be < NUM_REQ
//     id   out ID_BITS   chosen index (0 when none)
//     any  out 1         at least one request is set
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int ID_BITS = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BITS-1:0] ptr,
  output logic [ID_BITS-1:0] id,
  output logic               any
);

  int best;
  int offset;

  // Each request's distance from ptr (mod NUM_REQ) is its priority; the
  // smallest distance wins. Looping over bit positions keeps the request
  // index a loop constant instead of a run-time computed index.
  always_comb begin
    id     = '0;
    any    = 1'b0;
    best   = NUM_REQ;
    offset = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        offset = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
        if (offset < best) begin
          best = offset;
          id   = ID_BITS'(i);
          any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte-stream requesters with
//   packet-granular round-robin: an owner keeps the transmitter until it
//   hands over a byte marked req_last.
//   Optional feature macro: UART_TX_ARB_TAG_EN -- prefixes every packet with a
//   tag byte {TAG_BASE[7:ID_BITS], grant_id}.
//   Ports:
//     clk        in   1            system clock
//     rst        in   1            asynchronous active-high reset
//     req_valid  in   NUM_REQ      per-requester byte valid
//     req_data   in   NUM_REQ*8    packed bytes, requester i at [8*i+7:8*i]
//     req_last   in   NUM_REQ      byte is last of its packet
//     req_ready  out  NUM_REQ      byte accepted when valid & ready
//     tx_data    out  8            byte to the transmitter
//     tx_valid   out  1            tx_data valid
//     tx_ready   in   1            transmitter accepts byte this cycle
//     grant_id   out  ID_BITS      current owner, valid while busy
//     busy       out  1            packet in progress
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_BITS = 3
`ifdef UART_TX_ARB_TAG_EN
  ,
  parameter logic [7:0] TAG_BASE = 8'hA0
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*UART_DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]                req_last,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [UART_DATA_BITS-1:0]         tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic [ID_BITS-1:0]                grant_id,
  output logic                              busy
);

  arb_state_t                state;
  logic [ID_BITS-1:0]        rr_ptr;
  logic [ID_BITS-1:0]        pick_id;
  logic                      pick_any;
  logic                      lane_valid;
  logic                      lane_last;
  logic [UART_DATA_BITS-1:0] lane_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .id  (pick_id),
    .any (pick_any)
  );

  // Select the granted lane by comparing against every legal id, so an
  // id wider than needed never indexes past the request vectors.
  always_comb begin
    lane_valid = 1'b0;
    lane_last  = 1'b0;
    lane_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_BITS'(i)) begin
        lane_valid = req_valid[i];
        lane_last  = req_last[i];
        lane_data  = req_data[UART_DATA_BITS*i +: UART_DATA_BITS];
      end
    end
  end

  // Output mux: nothing moves in IDLE; PASS is a straight pass-through of
  // the owner's handshake, so a stalled owner simply shows tx_valid=0.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    case (state)
`ifdef UART_TX_ARB_TAG_EN
      TAG: begin
        tx_valid = 1'b1;
        tx_data  = {TAG_BASE[UART_DATA_BITS-1:ID_BITS], grant_id};
      end
`endif
      PASS: begin
        tx_valid = lane_valid;
        tx_data  = lane_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id == ID_BITS'(i)) begin
            req_ready[i] = tx_ready;
          end
        end
      end
      default: ;
    endcase
  end

  // Arbiter FSM. The pointer moves only when a packet completes, and wraps
  // at NUM_REQ so ids beyond the last requester are never produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_id;
            busy     <= 1'b1;
`ifdef UART_TX_ARB_TAG_EN
            state    <= TAG;
`else
            state    <= PASS;
`endif
          end
        end
`ifdef UART_TX_ARB_TAG_EN
        TAG: begin
          if (tx_ready) begin
            state <= PASS;
          end
        end
`endif
        PASS: begin
          if (lane_valid && tx_ready && lane_last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant_id == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=3). Requester lanes are fed
//   from per-lane byte queues; every byte expected on the transmitter side is
//   pushed to a scoreboard when stimulus is issued and popped on each tx
//   handshake. Honours UART_TX_ARB_TAG_EN for the expected tag bytes.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ID_BITS = 3;
`ifdef UART_TX_ARB_TAG_EN
  localparam int TAG_CYC = 1;
`else
  localparam int TAG_CYC = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [ID_BITS-1:0]   grant_id;
  logic                 busy;

  logic [8:0] laneQ0[$];
  logic [8:0] laneQ1[$];
  logic [8:0] laneQ2[$];
  logic [7:0] expQ[$];
  logic [NUM_REQ-1:0] hs;

  int checksTotal  = 0;
  int checksPassed = 0;

  uart_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    assert (observed === expected) checksPassed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  function automatic logic [7:0] tagByte(input int lane);
    return 8'hA0 | 8'(lane);
  endfunction

  function automatic logic [7:0] firstByte(input int lane, input logic [7:0] data);
`ifdef UART_TX_ARB_TAG_EN
    return tagByte(lane);
`else
    return data;
`endif
  endfunction

  task automatic expectPacket(input int lane);
`ifdef UART_TX_ARB_TAG_EN
    expQ.push_back(tagByte(lane));
`else
    if (lane < 0) expQ.push_back(8'h00);
`endif
  endtask

  task automatic applyStimulus(input int lane, input logic [7:0] data, input logic last);
    case (lane)
      0:       laneQ0.push_back({last, data});
      1:       laneQ1.push_back({last, data});
      default: laneQ2.push_back({last, data});
    endcase
  endtask

  // Drive each lane from the head of its queue.
  task automatic refreshLanes();
    if (laneQ0.size() != 0) begin
      req_valid[0] = 1'b1; req_data[7:0] = laneQ0[0][7:0]; req_last[0] = laneQ0[0][8];
    end else begin
      req_valid[0] = 1'b0; req_last[0] = 1'b0;
    end
    if (laneQ1.size() != 0) begin
      req_valid[1] = 1'b1; req_data[15:8] = laneQ1[0][7:0]; req_last[1] = laneQ1[0][8];
    end else begin
      req_valid[1] = 1'b0; req_last[1] = 1'b0;
    end
    if (laneQ2.size() != 0) begin
      req_valid[2] = 1'b1; req_data[23:16] = laneQ2[0][7:0]; req_last[2] = laneQ2[0][8];
    end else begin
      req_valid[2] = 1'b0; req_last[2] = 1'b0;
    end
  endtask

  // Step to 3 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic waitDrain(input string tag, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (expQ.size() == 0 && !busy && laneQ0.size() == 0 &&
          laneQ1.size() == 0 && laneQ2.size() == 0) break;
      tick();
    end
    checkOutput({tag, "_scoreboardLeft"}, 32'(expQ.size()), 32'd0);
    checkOutput({tag, "_busyAfter"}, {31'd0, busy}, 32'd0);
  endtask

  // Handshakes are sampled mid-cycle; they complete on the next rising edge.
  always @(negedge clk) begin
    hs = req_valid & req_ready;
    if (!rst && tx_valid && tx_ready) begin
      assert (expQ.size() != 0)
        checkOutput("txByte", {24'd0, tx_data}, {24'd0, expQ.pop_front()});
      else begin
        checksTotal++;
        $error("[TB] FAIL txUnexpected observed=%02h expected=none", tx_data);
      end
    end
  end

  // Retire accepted bytes and present the next ones just after each edge.
  always @(posedge clk) begin
    #1;
    if (hs[0]) void'(laneQ0.pop_front());
    if (hs[1]) void'(laneQ1.pop_front());
    if (hs[2]) void'(laneQ2.pop_front());
    refreshLanes();
  end

  initial begin
    rst       = 1'b1;
    tx_ready  = 1'b0;
    hs        = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("rstBusy",     {31'd0, busy},      32'd0);
    checkOutput("rstGrant",    {29'd0, grant_id},  32'd0);
    checkOutput("rstTxValid",  {31'd0, tx_valid},  32'd0);
    checkOutput("rstTxData",   {24'd0, tx_data},   32'd0);
    checkOutput("rstReqReady", {29'd0, req_ready}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: lone requester 1, two-byte packet
    $display("[TB] step 1: single requester");
    tx_ready = 1'b1;
    expectPacket(1);
    expQ.push_back(8'h41);
    expQ.push_back(8'h42);
    applyStimulus(1, 8'h41, 1'b0);
    applyStimulus(1, 8'h42, 1'b1);
    refreshLanes();
    tick();
    checkOutput("t1Grant",  {29'd0, grant_id}, 32'd1);
    checkOutput("t1Busy",   {31'd0, busy},     32'd1);
    checkOutput("t1First",  {24'd0, tx_data},  {24'd0, firstByte(1, 8'h41)});
    repeat (1 + TAG_CYC) tick();
    checkOutput("t1Second", {24'd0, tx_data},   32'h42);
    checkOutput("t1Ready",  {29'd0, req_ready}, 32'b010);
    tick();
    checkOutput("t1BusyDrop",  {31'd0, busy},     32'd0);
    checkOutput("t1ValidDrop", {31'd0, tx_valid}, 32'd0);
    waitDrain("t1", 20);

    // 2: all three requesters, single-byte packets, twice
    $display("[TB] step 2: round robin");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      expectPacket(0); expQ.push_back(8'h10);
      expectPacket(1); expQ.push_back(8'h20);
      expectPacket(2); expQ.push_back(8'h30);
      applyStimulus(0, 8'h10, 1'b1);
      applyStimulus(1, 8'h20, 1'b1);
      applyStimulus(2, 8'h30, 1'b1);
      refreshLanes();
      for (int p = 0; p < 3; p++) begin
        for (int c = 0; c <= TAG_CYC; c++) begin
          tick();
          checkOutput("t2Active", {31'd0, tx_valid}, 32'd1);
        end
        tick();
        checkOutput("t2IdleGap", {31'd0, tx_valid}, 32'd0);
      end
    end
    waitDrain("t2", 20);

    // 3: owner stalls mid-packet while requester 2 waits
    $display("[TB] step 3: owner stall");
    expectPacket(0);
    expQ.push_back(8'h01);
    expQ.push_back(8'h02);
    expQ.push_back(8'h03);
    expectPacket(2);
    expQ.push_back(8'h33);
    applyStimulus(0, 8'h01, 1'b0);
    applyStimulus(2, 8'h33, 1'b1);
    refreshLanes();
    for (int c = 0; c < 10; c++) begin
      if (laneQ0.size() == 0) break;
      tick();
    end
    checkOutput("t3FirstSent", 32'(laneQ0.size()), 32'd0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("t3StallValid", {31'd0, tx_valid},     32'd0);
      checkOutput("t3StallGrant", {29'd0, grant_id},     32'd0);
      checkOutput("t3StallBusy",  {31'd0, busy},         32'd1);
      checkOutput("t3NoReq2",     {31'd0, req_ready[2]}, 32'd0);
      tick();
    end
    applyStimulus(0, 8'h02, 1'b0);
    applyStimulus(0, 8'h03, 1'b1);
    refreshLanes();
    waitDrain("t3", 30);

    // 4: transmitter back-pressure for 20 cycles
    $display("[TB] step 4: tx backpressure");
    tx_ready = 1'b0;
    expectPacket(1);
    expQ.push_back(8'h77);
    applyStimulus(1, 8'h77, 1'b1);
    refreshLanes();
    tick();
    for (int c = 0; c < 20; c++) begin
      checkOutput("t4HoldValid", {31'd0, tx_valid},  32'd1);
      checkOutput("t4HoldData",  {24'd0, tx_data},   {24'd0, firstByte(1, 8'h77)});
      checkOutput("t4NoReady",   {29'd0, req_ready}, 32'd0);
      tick();
    end
    tx_ready = 1'b1;
    waitDrain("t4", 20);

    // 5: reset in the middle of a four-byte packet
    $display("[TB] step 5: reset mid-packet");
    expectPacket(0);
    expQ.push_back(8'h81);
    applyStimulus(0, 8'h81, 1'b0);
    applyStimulus(0, 8'h82, 1'b0);
    applyStimulus(0, 8'h83, 1'b0);
    applyStimulus(0, 8'h84, 1'b1);
    refreshLanes();
    repeat (2 + TAG_CYC) tick();
    checkOutput("t5Byte2", {24'd0, tx_data}, 32'h82);
    rst = 1'b1;
    laneQ0.delete();
    refreshLanes();
    tick();
    checkOutput("t5RstBusy",  {31'd0, busy},      32'd0);
    checkOutput("t5RstValid", {31'd0, tx_valid},  32'd0);
    checkOutput("t5RstReady", {29'd0, req_ready}, 32'd0);
    rst = 1'b0;
    tick();
    expectPacket(1); expQ.push_back(8'h91);
    expectPacket(2); expQ.push_back(8'h92);
    applyStimulus(1, 8'h91, 1'b1);
    applyStimulus(2, 8'h92, 1'b1);
    refreshLanes();
    tick();
    checkOutput("t5PtrReset", {29'd0, grant_id}, 32'd1);
    waitDrain("t5", 30);

    // 6: single-byte packet from requester 2 (tagged when enabled)
    $display("[TB] step 6: tag byte");
    expectPacket(2);
    expQ.push_back(8'h55);
    applyStimulus(2, 8'h55, 1'b1);
    refreshLanes();
    tick();
    checkOutput("t6Grant", {29'd0, grant_id}, 32'd2);
    checkOutput("t6First", {24'd0, tx_data},  {24'd0, firstByte(2, 8'h55)});
    waitDrain("t6", 20);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
